// File: rtl/rtob_pkg.sv
// Shared constants, dispatch classification and the level-width helper for the
// real-time output buffer.
package rtob_pkg;

    localparam int TS_W_DEF       = 64;
    localparam int DATA_W_DEF     = 64;
    localparam int DEPTH_DEF      = 8192;
    localparam int FULL_TH_MARGIN = 92;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        DSP_NONE  = 2'd0,
        DSP_MATCH = 2'd1,
        DSP_LATE  = 2'd2
    } dsp_kind_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rtob_fifo.sv
// Show-ahead FIFO: RAM-style storage array plus a registered head entry that
// acts as the RAM output stage.
module rtob_fifo
    import rtob_pkg::*;
#(
    parameter int EW      = TS_W_DEF + DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int FULL_TH = DEPTH_DEF - FULL_TH_MARGIN
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [EW-1:0]           din,
    output logic [EW-1:0]           head,
    output logic                    full,
    output logic                    empty,
    output logic [lvl_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level >= LW'(FULL_TH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign rd_nxt  = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_nxt;
            if (push_ok && !pop_ok)      level <= level + LW'(1);
            else if (!push_ok && pop_ok) level <= level - LW'(1);
        end
    end

    // The head bypasses the array when the incoming word is the only entry left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
        end else if (flush) begin
            head <= '0;
        end else if (push_ok && (empty || (pop_ok && level == LW'(1)))) begin
            head <= din;
        end else if (pop_ok && level != LW'(1)) begin
            head <= mem[rd_nxt];
        end
    end

endmodule

// File: rtl/rtob_param_core.sv
// Timestamp-driven dispatcher: releases FIFO entries when their timestamp meets
// the time base, and captures late-entry and overflow errors.
module rtob_param_core
    import rtob_pkg::*;
#(
    parameter int TS_W    = TS_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int FULL_TH = DEPTH - FULL_TH_MARGIN,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      auto_start,
    input  logic                      flush,
    input  logic                      late_mode,
    input  logic                      err_clear,
    input  logic                      write,
    input  logic [TS_W+DATA_W-1:0]    fifo_din,
    input  logic [TS_W-1:0]           counter,
    output logic [TS_W+DATA_W-1:0]    rto_out,
    output logic                      counter_matched,
    output logic                      timestamp_error,
    output logic                      overflow_error,
    output logic [TS_W+DATA_W-1:0]    timestamp_error_data,
    output logic [TS_W+DATA_W-1:0]    overflow_error_data,
    output logic                      ts_err_sticky,
    output logic                      ovf_err_sticky,
    output logic [CNT_W-1:0]          late_count,
    output logic [CNT_W-1:0]          ovf_count,
    output logic                      full,
    output logic                      empty,
    output logic [lvl_w(DEPTH)-1:0]   level
);
    localparam int EW = TS_W + DATA_W;

    logic [EW-1:0]   head;
    logic [TS_W-1:0] head_ts;
    dsp_kind_t       kind;
    logic            pop;
    logic            emit;
    logic            late_ev;
    logic            ovf_ev;

    rtob_fifo #(
        .EW      (EW),
        .DEPTH   (DEPTH),
        .FULL_TH (FULL_TH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (write),
        .pop     (pop),
        .din     (fifo_din),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign head_ts = head[EW-1:DATA_W];

    always_comb begin
        kind = DSP_NONE;
        if (auto_start && !empty && !flush) begin
            if (head_ts == counter)     kind = DSP_MATCH;
            else if (head_ts < counter) kind = DSP_LATE;
        end
    end

    assign pop     = (kind != DSP_NONE);
    assign late_ev = (kind == DSP_LATE);
    assign emit    = (kind == DSP_MATCH) || (late_ev && late_mode);
    // full reflects the pre-cycle level, so a same-cycle pop does not rescue a write.
    assign ovf_ev  = write & full & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rto_out              <= '0;
            counter_matched      <= 1'b0;
            timestamp_error      <= 1'b0;
            overflow_error       <= 1'b0;
            timestamp_error_data <= '0;
            overflow_error_data  <= '0;
        end else begin
            counter_matched <= emit;
            timestamp_error <= late_ev;
            overflow_error  <= ovf_ev;
            if (emit)    rto_out              <= head;
            if (late_ev) timestamp_error_data <= head;
            if (ovf_ev)  overflow_error_data  <= fifo_din;
        end
    end

    // An error event in the same cycle as err_clear wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_err_sticky  <= 1'b0;
            ovf_err_sticky <= 1'b0;
            late_count     <= '0;
            ovf_count      <= '0;
        end else begin
            if (late_ev) begin
                ts_err_sticky <= 1'b1;
                if (err_clear)         late_count <= CNT_W'(1);
                else if (~&late_count) late_count <= late_count + CNT_W'(1);
            end else if (err_clear) begin
                ts_err_sticky <= 1'b0;
                late_count    <= '0;
            end

            if (ovf_ev) begin
                ovf_err_sticky <= 1'b1;
                if (err_clear)        ovf_count <= CNT_W'(1);
                else if (~&ovf_count) ovf_count <= ovf_count + CNT_W'(1);
            end else if (err_clear) begin
                ovf_err_sticky <= 1'b0;
                ovf_count      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rtob_param_core.sv
// Self-checking bench for rtob_param_core: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_rtob_param_core;
    localparam int TS_W    = 16;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int FULL_TH = 12;
    localparam int CNT_W   = 4;
    localparam int EW      = TS_W + DATA_W;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset_n;
    logic              auto_start;
    logic              flush;
    logic              late_mode;
    logic              err_clear;
    logic              write;
    logic [EW-1:0]     fifo_din;
    logic [TS_W-1:0]   counter;
    logic [EW-1:0]     rto_out;
    logic              counter_matched;
    logic              timestamp_error;
    logic              overflow_error;
    logic [EW-1:0]     timestamp_error_data;
    logic [EW-1:0]     overflow_error_data;
    logic              ts_err_sticky;
    logic              ovf_err_sticky;
    logic [CNT_W-1:0]  late_count;
    logic [CNT_W-1:0]  ovf_count;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;

    rtob_param_core #(
        .TS_W    (TS_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .FULL_TH (FULL_TH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .auto_start           (auto_start),
        .flush                (flush),
        .late_mode            (late_mode),
        .err_clear            (err_clear),
        .write                (write),
        .fifo_din             (fifo_din),
        .counter              (counter),
        .rto_out              (rto_out),
        .counter_matched      (counter_matched),
        .timestamp_error      (timestamp_error),
        .overflow_error       (overflow_error),
        .timestamp_error_data (timestamp_error_data),
        .overflow_error_data  (overflow_error_data),
        .ts_err_sticky        (ts_err_sticky),
        .ovf_err_sticky       (ovf_err_sticky),
        .late_count           (late_count),
        .ovf_count            (ovf_count),
        .full                 (full),
        .empty                (empty),
        .level                (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an entry queue plus expected output registers.
    logic [EW-1:0] q[$];
    logic [EW-1:0] m_rto, m_ted, m_oed;
    bit            m_cm, m_te, m_oe, m_tss, m_ovs;
    int            m_lc, m_oc;

    task automatic m_reset();
        q.delete();
        m_rto = '0; m_ted = '0; m_oed = '0;
        m_cm = 0; m_te = 0; m_oe = 0; m_tss = 0; m_ovs = 0;
        m_lc = 0; m_oc = 0;
    endtask

    function automatic int cnt_upd(input int c, input bit ev, input bit clr);
        if (ev) return clr ? 1 : ((c == MAXC) ? c : c + 1);
        return clr ? 0 : c;
    endfunction

    task automatic m_step();
        bit            was_full;
        bit            l_ev;
        bit            o_ev;
        logic [EW-1:0] h;
        logic [TS_W-1:0] hts;
        was_full = (q.size() >= FULL_TH);
        l_ev = 0; o_ev = 0;
        m_cm = 0; m_te = 0; m_oe = 0;
        if (flush) begin
            q.delete();
        end else begin
            if (auto_start && q.size() > 0) begin
                h   = q[0];
                hts = h[EW-1:DATA_W];
                if (hts == counter) begin
                    void'(q.pop_front());
                    m_rto = h; m_cm = 1;
                end else if (hts < counter) begin
                    void'(q.pop_front());
                    m_te = 1; m_ted = h; l_ev = 1;
                    if (late_mode) begin m_rto = h; m_cm = 1; end
                end
            end
            if (write) begin
                if (was_full) begin m_oe = 1; m_oed = fifo_din; o_ev = 1; end
                else q.push_back(fifo_din);
            end
        end
        m_lc = cnt_upd(m_lc, l_ev, err_clear);
        m_oc = cnt_upd(m_oc, o_ev, err_clear);
        if (l_ev) m_tss = 1; else if (err_clear) m_tss = 0;
        if (o_ev) m_ovs = 1; else if (err_clear) m_ovs = 0;
    endtask

    task automatic compare_all();
        chk("rto_out",  rto_out, m_rto);
        chk("matched",  counter_matched, m_cm);
        chk("ts_err",   timestamp_error, m_te);
        chk("ts_data",  timestamp_error_data, m_ted);
        chk("ovf_err",  overflow_error, m_oe);
        chk("ovf_data", overflow_error_data, m_oed);
        chk("ts_stk",   ts_err_sticky, m_tss);
        chk("ovf_stk",  ovf_err_sticky, m_ovs);
        chk("late_cnt", late_count, m_lc);
        chk("ovf_cnt",  ovf_count, m_oc);
        chk("level",    level, q.size());
        chk("empty",    empty, q.size() == 0);
        chk("full",     full, q.size() >= FULL_TH);
    endtask

    int mc, tec, oec, both;

    // One clock: model sees the same inputs the DUT samples, outputs checked at negedge.
    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (counter_matched) mc++;
        if (timestamp_error) tec++;
        if (overflow_error) oec++;
        if (counter_matched && timestamp_error) both++;
        write = 0; flush = 0; err_clear = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input int ts, input int data);
        write = 1;
        fifo_din = {TS_W'(ts), DATA_W'(data)};
        tick();
    endtask

    initial begin
        reset_n = 0; auto_start = 0; flush = 0; late_mode = 0; err_clear = 0;
        write = 0; fifo_din = '0; counter = '0;
        m_reset();
        #3;
        compare_all();
        @(negedge clk);
        reset_n = 1;

        // In-order exact-match dispatch
        for (int i = 0; i < 3; i++) push(100 + i, 16'hA0 + i);
        counter = 98; auto_start = 1; mc = 0; tec = 0;
        for (int i = 0; i < 8; i++) begin tick(); counter = counter + 1'b1; end
        chk("s1_matches", mc, 3);
        chk("s1_errors", tec, 0);
        chk("s1_rto_ts", rto_out[EW-1:DATA_W], 102);

        // Late entry, drop mode
        late_mode = 0; counter = 60; mc = 0; tec = 0;
        push(50, 16'hBEEF);
        run(3);
        chk("s2_tec", tec, 1);
        chk("s2_late_cnt", late_count, 1);
        chk("s2_ts_data", timestamp_error_data[EW-1:DATA_W], 50);
        chk("s2_rto_hold", rto_out[EW-1:DATA_W], 102);

        // Late entry, emit mode
        late_mode = 1; mc = 0; tec = 0; both = 0;
        push(50, 16'hCAFE);
        run(3);
        chk("s3_together", both, 1);
        chk("s3_rto", rto_out, {16'd50, 16'hCAFE});
        chk("s3_late_cnt", late_count, 2);

        // Overflow with dispatch disabled
        err_clear = 1; tick();
        auto_start = 0; oec = 0;
        for (int i = 0; i < 14; i++) push(16'h9000 + i, 16'h5500 + i);
        chk("s4_level", level, 12);
        chk("s4_oec", oec, 2);
        chk("s4_ovf_data", overflow_error_data, {16'h900D, 16'h550D});
        chk("s4_ovf_cnt", ovf_count, 2);
        err_clear = 1; push(16'h9100, 16'h1);
        chk("s4_clr_prio", ovf_count, 1);
        for (int i = 0; i < 16; i++) push(16'h9200 + i, i);
        chk("s4_sat", ovf_count, MAXC);

        // Flush with a same-cycle write, then clear errors
        flush = 1; push(16'h9300, 16'h2);
        chk("s5_level", level, 0);
        chk("s5_empty", empty, 1);
        chk("s5_stk", ovf_err_sticky, 1);
        err_clear = 1; tick();
        chk("s5_clr_cnt", ovf_count, 0);
        chk("s5_clr_stk", ts_err_sticky | ovf_err_sticky, 0);

        // Streaming push/pop across pointer wrap with a mid-stream reset
        auto_start = 1; late_mode = 0; counter = 1000;
        for (int i = 0; i < 40; i++) begin
            if (i == 25) begin
                #3 reset_n = 0;
                #1 m_reset();
                compare_all();
                @(negedge clk);
                compare_all();
                reset_n = 1;
            end
            push(int'(counter) + 3, int'($urandom_range(0, 16'hFFFF)));
            counter = counter + 1'b1;
        end
        for (int i = 0; i < 5; i++) begin tick(); counter = counter + 1'b1; end
        chk("s6_drained", level, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            write      = ($urandom_range(0, 1) == 1);
            fifo_din   = {TS_W'(int'(counter) + int'($urandom_range(0, 8)) - 2),
                          DATA_W'($urandom)};
            auto_start = ($urandom_range(0, 4) != 0);
            late_mode  = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 39) == 0);
            err_clear  = ($urandom_range(0, 19) == 0);
            tick();
            counter = counter + TS_W'($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
